piece_queue_ctrl: RTL and testbench
===================================

Name: piece_queue_ctrl

Overview:
- Sequences shape IDs into the game: keeps a preview queue of upcoming pieces and fills it from a 7-bag randomizer.
- Hands the queue head to the spawn logic through a req/valid handshake; spawn_shape drives the shape decoder.
- Preview outputs feed the next-piece display decoders.

Parameters:
- QUEUE_DEPTH, 3, number of preview entries (1..6); entry 0 is the next piece.
- LFSR_SEED, 16'hACE1, nonzero reset value of the randomizer LFSR.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- spawn_req  in  1  level request for the next piece; requester holds it high until spawn_valid.
- spawn_valid  out  1  one-cycle pulse; spawn_shape is valid this cycle.
- spawn_shape  out  3  shape ID 0..6 (O,I,T,L,J,S,Z).
- queue_ready  out  1  queue full and controller in IDLE.
- preview_shapes  out  3*QUEUE_DEPTH  queue contents; entry i at bits [3i+2:3i].
- hold_req  in  1  swap request (HOLD_PIECE_EN only).
- hold_in  in  3  active piece being held (HOLD_PIECE_EN only).
- hold_valid  out  1  hold slot occupied (HOLD_PIECE_EN only).
- hold_shape  out  3  hold slot contents (HOLD_PIECE_EN only).

Behaviour:
- Reset: all outputs 0; queue entries 0, count 0; bag_mask 7'h00; LFSR=LFSR_SEED; hold slot empty, hold lock clear; state FILL.
- rst mid-fill or mid-spawn discards all contents; the refill restarts from LFSR_SEED.
- LFSR: 16-bit Galois, mask 16'hB400, advances every cycle including stalls. Candidate = lfsr[2:0].
- Draw: the candidate is accepted iff it is not 7 and its bag_mask bit is clear. On accept:
  - write the candidate to queue[count];
  - set its mask bit;
  - if the mask becomes 7'h7F, clear it in the same cycle.
- On reject: retry next cycle. At most one draw per cycle.
- FILL: draw until count==QUEUE_DEPTH, then go to IDLE.
- IDLE: queue_ready=1. On spawn_req:
  - spawn_valid=1 next cycle with spawn_shape = queue[0] as it was at request time;
  - queue shifts toward 0 and count decrements;
  - state goes to FILL. Latency is exactly 1 cycle from req sampled in IDLE.
- spawn_req is ignored outside IDLE (and so stays held). Back-to-back spawns are separated by refill time.
- spawn_shape holds its value between pulses. spawn_valid is never high two consecutive cycles.
- Invariants:
  - every 7 consecutive accepted draws aligned to bag boundaries contain 0..6 exactly once;
  - value 7 never appears on any output.
- Fairness bound for verification: each accepted draw completes within 256 cycles of starting.

Optional Feature:
- Macro: TETRIS_HOLD_PIECE_EN.
- With the macro, hold ports exist. A hold_req sampled in IDLE with the lock clear behaves as follows:
  - hold empty: store hold_in and perform a normal spawn (queue head out, then refill);
  - hold full: spawn_valid next cycle with spawn_shape = old hold_shape; store hold_in; queue untouched; stay IDLE.
  - In both cases set the lock.
- The lock clears on the next normal spawn_req service. hold_req while locked or outside IDLE is ignored.
- spawn_req wins if both requests are sampled in the same cycle.
- Without the macro, the hold ports are absent and the hold logic is not built.

Decomposition:
- Package tetris_pkg holds:
  - SHAPE_W=3 and NUM_SHAPES=7;
  - shape localparams SHAPE_O=0 through SHAPE_Z=6;
  - the state encoding (FILL, IDLE).
- Sub-module bag_randomizer holds the LFSR, mask and accept logic. It is a draw_en in, draw_valid/draw_shape out, cycle-accurate unit.

Test Plan:
- Reset, then run: queue_ready rises within QUEUE_DEPTH*256 cycles; all preview entries are in 0..6; the first 3 are distinct.
- Issue 14 spawns: each 7-spawn group from reset is a permutation of {0..6}; 7 never appears.
- spawn_req sampled in IDLE with preview entry0=4: spawn_valid pulses next cycle with spawn_shape=4; old entry1 moves to entry0.
- spawn_req asserted during FILL: no spawn_valid until IDLE; then exactly one pulse.
- Assert rst for one cycle mid-FILL: all outputs are 0; the following draw sequence is identical to the one after power-on reset.
- With TETRIS_HOLD_PIECE_EN:
  - hold_in=2 with hold empty: hold_shape=2, hold_valid=1, spawn of the queue head;
  - an immediate second hold_req is ignored;
  - after one normal spawn, hold_req with hold_in=5 spawns 2 and stores 5.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared shape encoding and controller state for the piece queue.
package tetris_pkg;

  localparam int SHAPE_W    = 3;
  localparam int NUM_SHAPES = 7;

  localparam logic [SHAPE_W-1:0] SHAPE_O = 3'd0;
  localparam logic [SHAPE_W-1:0] SHAPE_I = 3'd1;
  localparam logic [SHAPE_W-1:0] SHAPE_T = 3'd2;
  localparam logic [SHAPE_W-1:0] SHAPE_L = 3'd3;
  localparam logic [SHAPE_W-1:0] SHAPE_J = 3'd4;
  localparam logic [SHAPE_W-1:0] SHAPE_S = 3'd5;
  localparam logic [SHAPE_W-1:0] SHAPE_Z = 3'd6;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  // One-hot bag bit for a shape; the unused code 7 maps to no bit.
  function automatic logic [NUM_SHAPES-1:0] shape_bit(input logic [SHAPE_W-1:0] s);
    return (s <= SHAPE_Z) ? (NUM_SHAPES'(1) << s) : '0;
  endfunction

endpackage

// File: rtl/bag_randomizer.sv
// 7-bag shape randomizer: free-running Galois LFSR plus a bag mask that
// refuses shapes already drawn from the current bag.
module bag_randomizer
  import tetris_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               draw_en,
  output logic               draw_valid,
  output logic [SHAPE_W-1:0] draw_shape
);

  localparam logic [15:0]           LFSR_MASK = 16'hB400;
  localparam logic [NUM_SHAPES-1:0] FULL_BAG  = '1;

  logic [15:0]           lfsr;
  logic [NUM_SHAPES-1:0] bag_mask;
  logic [NUM_SHAPES-1:0] cand_bit;
  logic [NUM_SHAPES-1:0] mask_set;

  assign draw_shape = lfsr[SHAPE_W-1:0];
  assign cand_bit   = shape_bit(draw_shape);
  assign draw_valid = draw_en && (cand_bit != '0) && ((bag_mask & cand_bit) == '0);
  assign mask_set   = bag_mask | cand_bit;

  // LFSR steps every cycle; the bag empties in the same cycle it fills up.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr     <= LFSR_SEED;
      bag_mask <= '0;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
      if (draw_valid) begin
        bag_mask <= (mask_set == FULL_BAG) ? '0 : mask_set;
      end
    end
  end

endmodule

// File: rtl/piece_queue_ctrl.sv
// Preview queue of upcoming pieces, refilled from the bag randomizer and
// handed to spawn logic one piece per request.
// Optional hold slot built when TETRIS_HOLD_PIECE_EN is defined.
//
// state   | meaning
// FILL    | drawing shapes until the queue holds QUEUE_DEPTH entries
// IDLE    | queue full, waiting for a spawn (or hold) request
module piece_queue_ctrl
  import tetris_pkg::*;
#(
  parameter int          QUEUE_DEPTH = 3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         spawn_req,
  output logic                         spawn_valid,
  output logic [SHAPE_W-1:0]           spawn_shape,
  output logic                         queue_ready,
  output logic [SHAPE_W*QUEUE_DEPTH-1:0] preview_shapes
`ifdef TETRIS_HOLD_PIECE_EN
  ,
  input  logic                         hold_req,
  input  logic [SHAPE_W-1:0]           hold_in,
  output logic                         hold_valid,
  output logic [SHAPE_W-1:0]           hold_shape
`endif
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [SHAPE_W-1:0] queue [QUEUE_DEPTH];
  logic               draw_en;
  logic               draw_valid;
  logic [SHAPE_W-1:0] draw_shape;
  logic               take_head;
`ifdef TETRIS_HOLD_PIECE_EN
  logic               hold_lock;
  logic               swap_hold;
`endif

  assign draw_en = (state == ST_FILL) && (count < CNT_W'(QUEUE_DEPTH));

`ifdef TETRIS_HOLD_PIECE_EN
  // An empty hold slot still consumes the queue head; a full one swaps instead.
  assign take_head = (state == ST_IDLE) &&
                     (spawn_req || (hold_req && !hold_lock && !hold_valid));
  assign swap_hold = (state == ST_IDLE) && !spawn_req &&
                     hold_req && !hold_lock && hold_valid;
`else
  assign take_head = (state == ST_IDLE) && spawn_req;
`endif

  bag_randomizer #(.LFSR_SEED(LFSR_SEED)) u_bag (
    .clk        (clk),
    .rst        (rst),
    .draw_en    (draw_en),
    .draw_valid (draw_valid),
    .draw_shape (draw_shape)
  );

  // Flatten the queue onto the preview bus, entry 0 in the low bits.
  always_comb begin
    preview_shapes = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      preview_shapes[SHAPE_W*i +: SHAPE_W] = queue[i];
    end
  end

  // Queue FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_FILL;
      count       <= '0;
      spawn_valid <= 1'b0;
      spawn_shape <= '0;
      queue_ready <= 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) queue[i] <= '0;
`ifdef TETRIS_HOLD_PIECE_EN
      hold_valid  <= 1'b0;
      hold_shape  <= '0;
      hold_lock   <= 1'b0;
`endif
    end else begin
      spawn_valid <= 1'b0;
      case (state)
        ST_FILL: begin
          if (draw_valid) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
              if (count == CNT_W'(i)) queue[i] <= draw_shape;
            end
            count <= count + CNT_W'(1);
            if (count == CNT_W'(QUEUE_DEPTH - 1)) begin
              state       <= ST_IDLE;
              queue_ready <= 1'b1;
            end
          end else if (count == CNT_W'(QUEUE_DEPTH)) begin
            state       <= ST_IDLE;
            queue_ready <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (take_head) begin
            spawn_valid <= 1'b1;
            spawn_shape <= queue[0];
            for (int i = 0; i < QUEUE_DEPTH - 1; i++) queue[i] <= queue[i+1];
            queue[QUEUE_DEPTH-1] <= '0;
            count       <= count - CNT_W'(1);
            state       <= ST_FILL;
            queue_ready <= 1'b0;
`ifdef TETRIS_HOLD_PIECE_EN
            if (spawn_req) begin
              hold_lock <= 1'b0;
            end else begin
              hold_lock  <= 1'b1;
              hold_valid <= 1'b1;
              hold_shape <= hold_in;
            end
`endif
          end
`ifdef TETRIS_HOLD_PIECE_EN
          else if (swap_hold) begin
            spawn_valid <= 1'b1;
            spawn_shape <= hold_shape;
            hold_shape  <= hold_in;
            hold_lock   <= 1'b1;
          end
`endif
        end
        default: state <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_piece_queue_ctrl.sv
// Directed bench for piece_queue_ctrl with a cycle-level reference model.
// Hold-slot steps are included when TETRIS_HOLD_PIECE_EN is defined.
module tb_piece_queue_ctrl;

  localparam int          D    = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic           clk = 1'b0;
  logic           rst;
  logic           spawn_req;
  logic           spawn_valid;
  logic [2:0]     spawn_shape;
  logic           queue_ready;
  logic [3*D-1:0] preview_shapes;
`ifdef TETRIS_HOLD_PIECE_EN
  logic           hold_req;
  logic [2:0]     hold_in;
  logic           hold_valid;
  logic [2:0]     hold_shape;
`endif

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [15:0] m_lfsr;
  logic [6:0]  m_mask;
  int          m_q[$];
  bit          m_fill, m_ready, m_sv;
  int          m_ss;
  bit          m_hv, m_lock;
  int          m_hs;

  always #5 clk = ~clk;

  piece_queue_ctrl #(.QUEUE_DEPTH(D), .LFSR_SEED(SEED)) dut (
    .clk            (clk),
    .rst            (rst),
    .spawn_req      (spawn_req),
    .spawn_valid    (spawn_valid),
    .spawn_shape    (spawn_shape),
    .queue_ready    (queue_ready),
    .preview_shapes (preview_shapes)
`ifdef TETRIS_HOLD_PIECE_EN
    ,
    .hold_req       (hold_req),
    .hold_in        (hold_in),
    .hold_valid     (hold_valid),
    .hold_shape     (hold_shape)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3*D-1:0] pack();
    logic [3*D-1:0] r = '0;
    for (int i = 0; i < D; i++) if (i < m_q.size()) r[3*i +: 3] = 3'(m_q[i]);
    return r;
  endfunction

  task automatic m_pop();
    m_sv    = 1'b1;
    m_ss    = m_q.pop_front();
    m_fill  = 1'b1;
    m_ready = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic [2:0] c;
    if (rst) begin
      m_lfsr = SEED; m_mask = '0; m_q.delete(); m_fill = 1'b1;
      m_ready = 1'b0; m_sv = 1'b0; m_ss = 0;
      m_hv = 1'b0; m_lock = 1'b0; m_hs = 0;
    end else begin
      c    = m_lfsr[2:0];
      m_sv = 1'b0;
      if (m_fill) begin
        if (m_q.size() < D && c != 3'd7 && !m_mask[c]) begin
          m_q.push_back(int'(c));
          m_mask[c] = 1'b1;
          if (m_mask == 7'h7F) m_mask = '0;
          if (m_q.size() == D) begin m_fill = 1'b0; m_ready = 1'b1; end
        end
      end else if (spawn_req) begin
        m_pop();
        m_lock = 1'b0;
      end
`ifdef TETRIS_HOLD_PIECE_EN
      else if (hold_req && !m_lock) begin
        m_lock = 1'b1;
        if (!m_hv) begin
          m_hv = 1'b1; m_hs = int'(hold_in); m_pop();
        end else begin
          m_sv = 1'b1; m_ss = m_hs; m_hs = int'(hold_in);
        end
      end
`endif
      m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("spawn_valid", 32'(spawn_valid), 32'(m_sv));
    chk("spawn_shape", 32'(spawn_shape), 32'(m_ss));
    chk("queue_ready", 32'(queue_ready), 32'(m_ready));
    chk("preview", 32'(preview_shapes), 32'(pack()));
`ifdef TETRIS_HOLD_PIECE_EN
    chk("hold_valid", 32'(hold_valid), 32'(m_hv));
    chk("hold_shape", 32'(hold_shape), 32'(m_hs));
`endif
    if (spawn_valid) chk("no_seven", 32'(spawn_shape != 3'd7), 32'd1);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!m_ready && n < D*256) begin tick(); n++; end
    chk(tag, 32'(queue_ready), 32'd1);
  endtask

  // Hold spawn_req until the pulse, then confirm exactly one pulse.
  task automatic do_spawn(output int shape);
    int n = 0;
    int pulses = 0;
    spawn_req = 1'b1;
    while (!m_sv && n < D*256 + 4) begin
      tick(); n++;
      if (spawn_valid) pulses++;
    end
    chk("spawn_timeout", 32'(m_sv), 32'd1);
    shape = int'(spawn_shape);
    spawn_req = 1'b0;
    tick();
    if (spawn_valid) pulses++;
    chk("one_pulse", 32'(pulses), 32'd1);
  endtask

  initial begin
    int             sh[14];
    int             s;
    int             hd, nx;
    logic [6:0]     seen;
    logic [3*D-1:0] p0;
    logic [2:0]     e0, e1, e2;

    rst = 1'b1; spawn_req = 1'b0;
`ifdef TETRIS_HOLD_PIECE_EN
    hold_req = 1'b0; hold_in = 3'd0;
`endif
    tick(); tick();
    chk("rst_valid", 32'(spawn_valid), 32'd0);
    chk("rst_ready", 32'(queue_ready), 32'd0);
    chk("rst_preview", 32'(preview_shapes), 32'd0);
    rst = 1'b0;

    wait_ready("first_ready");
    p0 = pack();
    e0 = preview_shapes[2:0]; e1 = preview_shapes[5:3]; e2 = preview_shapes[8:6];
    chk("range0", 32'(e0 < 3'd7), 32'd1);
    chk("range1", 32'(e1 < 3'd7), 32'd1);
    chk("range2", 32'(e2 < 3'd7), 32'd1);
    chk("distinct", 32'(e0 != e1 && e0 != e2 && e1 != e2), 32'd1);

    // first spawn from IDLE: head out next cycle, old entry 1 becomes entry 0
    hd = m_q[0]; nx = m_q[1];
    do_spawn(s);
    sh[0] = s;
    chk("head_out", 32'(s), 32'(hd));
    chk("shifted", 32'(preview_shapes[2:0]), 32'(nx));

    // remaining spawns are requested while the queue is refilling
    for (int k = 1; k < 14; k++) begin
      do_spawn(s);
      sh[k] = s;
    end
    for (int g = 0; g < 2; g++) begin
      seen = '0;
      for (int k = 0; k < 7; k++) seen = seen | (7'd1 << sh[g*7+k]);
      chk("bag_perm", 32'(seen), 32'h7F);
    end

    // reset in the middle of a refill
    do_spawn(s);
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_valid", 32'(spawn_valid), 32'd0);
    chk("midrst_shape", 32'(spawn_shape), 32'd0);
    chk("midrst_ready", 32'(queue_ready), 32'd0);
    chk("midrst_preview", 32'(preview_shapes), 32'd0);
    rst = 1'b0;
    wait_ready("ready_after_rst");
    chk("replay", 32'(preview_shapes), 32'(p0));

`ifdef TETRIS_HOLD_PIECE_EN
    begin
      int n;
      int pulses;
      hd = m_q[0];
      hold_in = 3'd2; hold_req = 1'b1;
      n = 0;
      while (!m_sv && n < 8) begin tick(); n++; end
      chk("hold1_valid", 32'(spawn_valid), 32'd1);
      chk("hold1_shape", 32'(spawn_shape), 32'(hd));
      chk("hold1_store", 32'(hold_shape), 32'd2);
      chk("hold1_full", 32'(hold_valid), 32'd1);
      // keep hold_req high: locked, so nothing more happens
      hold_in = 3'd3;
      pulses = 0;
      n = 0;
      while (!m_ready && n < D*256) begin
        tick(); n++;
        if (spawn_valid) pulses++;
      end
      for (int k = 0; k < 3; k++) begin tick(); if (spawn_valid) pulses++; end
      chk("hold_locked", 32'(pulses), 32'd0);
      chk("hold_kept", 32'(hold_shape), 32'd2);
      hold_req = 1'b0;
      do_spawn(s);
      wait_ready("ready_before_swap");
      hold_in = 3'd5; hold_req = 1'b1;
      n = 0;
      while (!m_sv && n < 8) begin tick(); n++; end
      chk("swap_shape", 32'(spawn_shape), 32'd2);
      chk("swap_store", 32'(hold_shape), 32'd5);
      hold_req = 1'b0;
      tick();
      chk("swap_idle", 32'(queue_ready), 32'd1);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
